word_bus_arbiter: RTL
=====================

Name: word_bus_arbiter

Overview:
- Round-robin time-slot arbiter that shares the single 9-bit tagged word bus between N_REQ word sources, e.g. the BCD counter's D:U and M:C words, an alarm word and a message word.
- Each granted source owns the bus for a fixed slot of SLOT_TKS cycles, followed by a guard gap.
- Sits between the word producers and the display/serial consumer, replacing blink-driven bus selection.

Parameters:
- N_REQ, 4, number of requesters (legal 2..8).
- SLOT_TKS, 12_500_000, cycles a granted word is held on the bus (500 ms at 25 MHz); legal >= 1.
- GAP_TKS, 1, cycles bus_valid is low between slots; legal >= 1.

Ports:
- clk  input  1  system clock, 25 MHz.
- reset_n  input  1  reset; asynchronous and active-low.
- enable  input  1  synchronous; when low, no new grants are issued.
- req  input  N_REQ  level request per source.
- req_word  input  9*N_REQ  word of source i on bits [9i+8:9i]; bit 8 is the source's own tag.
- grant  output  N_REQ  one-hot owner of the current slot; all zeros when no slot is active.
- ack  output  N_REQ  one-cycle pulse to the owner when its slot completes.
- word_bus  output  9  latched word of the owner; 0 when not valid.
- bus_valid  output  1  high while a slot is active.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Async reset (reset_n=0), applied immediately, even mid-slot:
  - state=IDLE, grant=0, ack=0, word_bus=0, bus_valid=0, busy=0.
  - rr_ptr=0, slot_cnt=0, gap_cnt=0.
- All outputs are registered.
- Arbitration event (in IDLE, or on the last GAP cycle):
  - If enable=1 and |req: winner = first set req[i] searching i = rr_ptr, rr_ptr+1, ... mod N_REQ.
  - On that edge: grant <= onehot(winner), word_bus <= req_word[winner], bus_valid <= 1, slot_cnt <= 0, state <= HOLD.
  - Otherwise: state <= IDLE.
- Latency: req sampled high at edge k in IDLE gives grant/bus_valid high after edge k.
- HOLD:
  - slot_cnt increments each cycle. bus_valid stays high for exactly SLOT_TKS cycles.
  - word_bus is frozen; req_word changes are ignored.
  - Edge with slot_cnt==SLOT_TKS-1:
    - ack <= onehot(winner), grant <= 0, bus_valid <= 0, word_bus <= 0.
    - rr_ptr <= (winner+1) mod N_REQ (wraps N_REQ-1 -> 0), gap_cnt <= 0, state <= GAP.
- GAP:
  - Lasts GAP_TKS cycles. ack is high only during the first GAP cycle.
  - Edge with gap_cnt==GAP_TKS-1 performs the arbitration event. Back-to-back slots are therefore separated by exactly GAP_TKS invalid cycles.
- Handshake:
  - A source holds req until it sees ack.
  - req still high after ack is a new request; it competes at the next arbitration with lowest round-robin priority.
  - req dropping during HOLD does not abort the slot; ack still pulses.
- enable low during HOLD or GAP: the current slot and gap complete normally; the next arbitration grants nothing and goes to IDLE.
- Simultaneous requests: resolved solely by rr_ptr. grant is never multi-hot.
- Bus tag bit 8 passes through unmodified.
- busy = (state != IDLE).

Optional Feature:
- Macro WORD_BUS_ARB_FIXED_PRIO0_EN.
- Defined:
  - At every arbitration, req[0]=1 wins unconditionally and rr_ptr is not updated.
  - Other sources rotate among 1..N_REQ-1 using rr_ptr, which skips index 0.
  - Used for an alarm word that must preempt the next slot, never the current one.
- Undefined: pure round-robin over all N_REQ sources as described.

Test Plan (N_REQ=4, SLOT_TKS=4, GAP_TKS=1):
- Reset check: reset_n=0 with req=4'b1111 -> grant=0, ack=0, word_bus=0, bus_valid=0, busy=0. Release -> first grant is 4'b0001.
- Single request: req=4'b0010 with word 9'h123 from IDLE -> after one edge grant=0010, word_bus=9'h123, bus_valid=1 for 4 cycles; then ack=0010 for 1 cycle and bus_valid=0 for 1 cycle. If req is held, regrant follows.
- Fairness: req=4'b1111 held continuously -> grant sequence 0001, 0010, 0100, 1000, 0001. Each slot is 4 valid cycles with 1 invalid cycle between; rr_ptr wraps from 3 to 0.
- Frozen word: req_word[0] changes 9'h045 -> 9'h046 mid-HOLD -> word_bus stays 9'h045 for the whole slot; the next slot of source 0 shows 9'h046.
- Enable gating: enable dropped on cycle 2 of a slot -> slot completes and ack pulses; then IDLE with busy=0 despite req=1111. Re-raising enable grants the next source after rr_ptr.
- Mid-operation reset: reset_n pulsed low in HOLD cycle 3 -> outputs 0 immediately, no ack. With WORD_BUS_ARB_FIXED_PRIO0_EN and req=1111 after release -> source 0 wins every arbitration.

Source files
------------

// File: rtl/word_bus_arbiter.sv
// Round-robin time-slot arbiter for the shared 9-bit tagged word bus.
// Optional macro WORD_BUS_ARB_FIXED_PRIO0_EN gives source 0 absolute priority at every arbitration.
module word_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int SLOT_TKS = 12_500_000,
  parameter int GAP_TKS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [N_REQ-1:0]     req,
  input  logic [9*N_REQ-1:0]   req_word,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     ack,
  output logic [8:0]           word_bus,
  output logic                 bus_valid,
  output logic                 busy
);

  localparam int PW  = $clog2(N_REQ);
  localparam int PW1 = PW + 1;
  localparam int SW  = (SLOT_TKS > 1) ? $clog2(SLOT_TKS) : 1;
  localparam int GW  = (GAP_TKS > 1) ? $clog2(GAP_TKS) : 1;

  localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_TKS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TKS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [8:0]       word_q, word_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    winner_q, winner_d;

  logic [8:0]       word_arr [N_REQ];
  logic [N_REQ-1:0] win_onehot;
  logic [PW-1:0]    win_idx;
  logic             win_vld;
  logic [PW1-1:0]   scan;
  logic [PW-1:0]    scan_base;
  logic [PW-1:0]    rr_next;
  logic             arb;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_src
      assign word_arr[gi]   = req_word[9*gi +: 9];
      assign win_onehot[gi] = (win_idx == PW'(gi));
    end
  endgenerate

`ifdef WORD_BUS_ARB_FIXED_PRIO0_EN
  // Sources 1..N_REQ-1 rotate; source 0 overrides whatever the rotation picked.
  always_comb begin
    win_idx   = '0;
    win_vld   = 1'b0;
    scan      = '0;
    scan_base = (rr_ptr_q == '0) ? PW'(1) : rr_ptr_q;
    for (int k = 0; k < N_REQ - 1; k++) begin
      scan = {1'b0, scan_base} + PW1'(k);
      if (scan > {1'b0, LAST_IDX}) scan = scan - PW1'(N_REQ - 1);
      if (!win_vld && req[scan[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[PW-1:0];
      end
    end
    if (req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
  end

  always_comb begin
    if (winner_q == '0)            rr_next = rr_ptr_q;
    else if (winner_q == LAST_IDX) rr_next = PW'(1);
    else                           rr_next = winner_q + PW'(1);
  end
`else
  always_comb begin
    win_idx   = '0;
    win_vld   = 1'b0;
    scan      = '0;
    scan_base = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, scan_base} + PW1'(k);
      if (scan > {1'b0, LAST_IDX}) scan = scan - PW1'(N_REQ);
      if (!win_vld && req[scan[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[PW-1:0];
      end
    end
  end

  always_comb begin
    if (winner_q == LAST_IDX) rr_next = '0;
    else                      rr_next = winner_q + PW'(1);
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ack_d    = '0;
    word_d   = word_q;
    valid_d  = valid_q;
    slot_d   = slot_q;
    gap_d    = gap_q;
    rr_ptr_d = rr_ptr_q;
    winner_d = winner_q;
    arb      = 1'b0;
    case (state_q)
      ST_IDLE: arb = 1'b1;
      ST_HOLD: begin
        if (slot_q == SLOT_LAST) begin
          ack_d    = grant_q;
          grant_d  = '0;
          valid_d  = 1'b0;
          word_d   = '0;
          rr_ptr_d = rr_next;
          gap_d    = '0;
          state_d  = ST_GAP;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) arb = 1'b1;
        else                   gap_d = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // The arbitration path overrides the per-state defaults above.
    if (arb) begin
      if (enable && win_vld) begin
        grant_d  = win_onehot;
        word_d   = word_arr[win_idx];
        valid_d  = 1'b1;
        slot_d   = '0;
        winner_d = win_idx;
        state_d  = ST_HOLD;
      end else begin
        state_d = ST_IDLE;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      slot_q   <= '0;
      gap_q    <= '0;
      rr_ptr_q <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      slot_q   <= slot_d;
      gap_q    <= gap_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign word_bus  = word_q;
  assign bus_valid = valid_q;
  assign busy      = busy_q;

endmodule
